dmem_resp: RTL and testbench
============================

DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, meaning word-address width; storage is 2**DEPTH_LOG2 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, legal range 1..15, meaning cycles from request acceptance to first rsp_valid.
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 SHALL have port req_valid  input  1  CPU-side request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_be  input  4  store byte enables; bit i enables bits 8i+7..8i.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load data.
REQ-014 SHALL have port rsp_err  output  1  request was misaligned or out of range.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both 1, latching write, addr, wdata and be.
REQ-017 SHALL, on acceptance, go to RESP if LATENCY = 1, else to WAIT with a down-counter loaded with LATENCY-1.
REQ-018 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 1, so that rsp_valid first rises exactly LATENCY cycles after the accepting edge.
REQ-019 SHALL flag an error when latched addr[1:0] != 0 or when any bit of addr[31:DEPTH_LOG2+2] is 1.
REQ-020 SHALL, for a valid store, update only the enabled bytes of word addr[DEPTH_LOG2+1:2] on the edge entering RESP; be = 0000 is a legal no-op with rsp_err = 0.
REQ-021 SHALL, for a valid load, register the full word, ignoring be, on the edge entering RESP.
REQ-022 SHALL drive rsp_rdata = 0 for stores and for errored requests; an errored store SHALL NOT modify storage.
REQ-023 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-024 SHALL NOT accept a new request in the cycle a response completes; the next acceptance is earliest one cycle after the return to IDLE, and one transaction is outstanding at most.
REQ-025 SHALL ignore req_* inputs outside IDLE and rsp_ready outside RESP.
REQ-026 SHALL make a load issued after a completed store to the same word return the merged store data.

Reset
REQ-027 SHALL, while reset = 0, force state IDLE, counter 0, req_ready 1, rsp_valid 0, rsp_rdata 0 and rsp_err 0, asynchronously.
REQ-028 SHALL abort any transaction in WAIT or RESP on reset with no response; a store not yet in RESP SHALL NOT be written.
REQ-029 SHALL NOT clear storage contents on reset.
REQ-030 SHALL accept a request on the first rising edge after reset returns to 1.

Verification
REQ-031 SHALL cover: store 0xDEADBEEF to 0x10 with be = 1111 and LATENCY = 2, then load 0x10 -> rsp_valid 2 cycles after each acceptance; load returns 0xDEADBEEF with rsp_err = 0.
REQ-032 SHALL cover: store 0x000000AA to 0x10 with be = 0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-033 SHALL cover: load 0x12, and load 0x100 with DEPTH_LOG2 = 6 -> rsp_err = 1 and rsp_rdata = 0; storage unchanged.
REQ-034 SHALL cover: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable; req_ready = 0 throughout; a req_valid pulse in this window is ignored.
REQ-035 SHALL cover: assert reset in WAIT during a store to 0x20 -> outputs return to reset values immediately; a later load of 0x20 returns the old contents.
REQ-036 SHALL cover: LATENCY = 1 with back-to-back requests and rsp_ready held 1 -> one accept every 3 cycles; rsp_valid is high for one cycle per request.

Source files
------------

// File: rtl/dmem_resp.sv
// Data-memory responder: single-outstanding load/store with fixed latency.
// Byte-enabled stores; misaligned or out-of-range requests return an error.
module dmem_resp #(
  parameter int DEPTH_LOG2 = 6,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        turn;
  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_be;
  logic [31:0] mem [2**DEPTH_LOG2];

  logic                  accept;
  logic                  enter_resp;
  logic                  op_write;
  logic                  op_err;
  logic [31:0]           op_addr;
  logic [31:0]           op_wdata;
  logic [3:0]            op_be;
  logic [DEPTH_LOG2-1:0] op_idx;

  // turn blocks acceptance for one IDLE cycle after a response completes
  assign req_ready = (state == IDLE) && !turn;
  assign rsp_valid = (state == RESP);
  assign accept    = req_valid && req_ready;

  // With LATENCY 1 the RESP edge is the accept edge, so use live inputs
  assign op_write = (LATENCY == 1) ? req_write : lat_write;
  assign op_addr  = (LATENCY == 1) ? req_addr  : lat_addr;
  assign op_wdata = (LATENCY == 1) ? req_wdata : lat_wdata;
  assign op_be    = (LATENCY == 1) ? req_be    : lat_be;

  assign op_err = (op_addr[1:0] != 2'b00) ||
                  (op_addr[31:DEPTH_LOG2+2] != '0);
  assign op_idx = op_addr[DEPTH_LOG2+1:2];

  assign enter_resp = ((LATENCY == 1) && accept) ||
                      ((state == WAIT) && (cnt == 4'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      turn      <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          turn <= 1'b0;
          if (accept) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            state <= RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
            turn  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (enter_resp) begin
        rsp_err   <= op_err;
        rsp_rdata <= (!op_write && !op_err) ? mem[op_idx] : 32'd0;
      end
    end
  end

  // Storage is never reset; reset gating keeps an aborted store out
  always_ff @(posedge clk) begin
    if (enter_resp && reset && op_write && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (op_be[b]) mem[op_idx][8*b +: 8] <= op_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Scoreboard bench for dmem_resp: LATENCY 2 instance for data/error/hold/
// reset cases, LATENCY 1 instance for back-to-back throughput.
module tb_dmem_resp;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        b_req_valid = 1'b0;
  logic        b_req_ready;
  logic        b_req_write = 1'b0;
  logic [31:0] b_req_addr = 32'd0;
  logic [31:0] b_req_wdata = 32'd0;
  logic [3:0]  b_req_be = 4'd0;
  logic        b_rsp_valid;
  logic        b_rsp_ready = 1'b0;
  logic [31:0] b_rsp_rdata;
  logic        b_rsp_err;

  int n_checks = 0;
  int n_fail = 0;

  logic [32:0] sb[$];
  logic [32:0] sb1[$];
  logic [31:0] model[64];
  logic [31:0] model1[4];
  int          acc_cyc[$];

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_LOG2(6), .LATENCY(LAT)) u0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_resp #(.DEPTH_LOG2(6), .LATENCY(1)) u1 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .req_be(b_req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] be,
                     input int hold, output int waits);
    logic        e;
    logic [31:0] x;
    logic [31:0] snap_d;
    logic        snap_e;
    logic [32:0] ex;
    int          n;
    e = (a[1:0] != 2'b00) || (a[31:8] != 24'd0);
    x = 32'd0;
    if (!e && !w) x = model[a[7:2]];
    if (!e && w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[a[7:2]][8*b +: 8] = d[8*b +: 8];
    end
    sb.push_back({e, x});
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    waits = n;
    if (n >= 20) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_be    = 4'($urandom);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 20);
    check("latency", 32'(n), 32'(LAT));
    if (hold > 0) begin
      snap_d = rsp_rdata;
      snap_e = rsp_err;
      for (int i = 0; i < hold; i++) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_req_ready", 32'(req_ready), 32'd0);
        check("hold_rdata", rsp_rdata, snap_d);
        check("hold_err", 32'(rsp_err), 32'(snap_e));
        req_valid = (i == 1);
        req_write = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'h12345678;
        req_be    = 4'hf;
        @(negedge clk);
      end
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      ex = sb.pop_front();
      check("rdata", rsp_rdata, ex[31:0]);
      check("err", 32'(rsp_err), 32'(ex[32]));
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check("rsp_done", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          w;
    int          k;
    logic [32:0] ex;

    #2;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hf, 0, w);
    check("first_accept", 32'(w), 32'd0);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 0, w);
    txn(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, w);
    txn(1'b0, 32'h10, 32'd0, 4'hf, 0, w);
    txn(1'b0, 32'h12, 32'd0, 4'hf, 0, w);
    txn(1'b0, 32'h100, 32'd0, 4'hf, 0, w);
    txn(1'b1, 32'h110, 32'h55555555, 4'hf, 0, w);
    txn(1'b1, 32'h11, 32'h66666666, 4'hf, 0, w);
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, w);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 5, w);
    txn(1'b1, 32'h14, 32'hA5A5A5A5, 4'hf, 0, w);
    txn(1'b1, 32'h14, 32'h3C3C3C3C, 4'ha, 0, w);
    txn(1'b0, 32'h14, 32'd0, 4'h0, 0, w);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 0, w);

    txn(1'b1, 32'h20, 32'hCAFEF00D, 4'hf, 0, w);
    txn(1'b0, 32'h20, 32'd0, 4'hf, 0, w);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h0BADBAD0;
    req_be    = 4'hf;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check("abort_accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_wait", 32'(rsp_valid), 32'd0);
    check("abort_rdata_before", rsp_rdata, 32'hCAFEF00D);
    reset = 1'b0;
    #1;
    check("abort_req_ready", 32'(req_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_err", 32'(rsp_err), 32'd0);
    repeat (3) @(posedge clk);
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    #1;
    reset = 1'b1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    txn(1'b0, 32'h20, 32'd0, 4'hf, 0, w);
    check("post_rst_accept", 32'(w), 32'd0);

    k = 0;
    b_rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (b_rsp_valid) begin
        if (sb1.size() == 0) begin
          check("b_sb_empty", 32'd1, 32'd0);
        end else begin
          ex = sb1.pop_front();
          check("b_rdata", b_rsp_rdata, ex[31:0]);
          check("b_err", 32'(b_rsp_err), 32'(ex[32]));
        end
      end
      b_req_valid = 1'b1;
      b_req_write = (k < 4);
      b_req_addr  = 32'((k % 4) * 4);
      b_req_wdata = 32'(k + 1) * 32'h01010101;
      b_req_be    = 4'hf;
      if (b_req_ready) begin
        if (k < 4) begin
          model1[k] = b_req_wdata;
          sb1.push_back({1'b0, 32'd0});
        end else begin
          sb1.push_back({1'b0, model1[k % 4]});
        end
        acc_cyc.push_back(c);
        k++;
      end
    end
    b_req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (b_rsp_valid) begin
        if (sb1.size() == 0) begin
          check("b_sb_empty", 32'd1, 32'd0);
        end else begin
          ex = sb1.pop_front();
          check("b_rdata", b_rsp_rdata, ex[31:0]);
          check("b_err", 32'(b_rsp_err), 32'(ex[32]));
        end
      end
    end
    check("b_sb_drained", 32'(sb1.size()), 32'd0);
    check("b_accepts", 32'(acc_cyc.size() >= 9), 32'd1);
    for (int i = 1; i < acc_cyc.size(); i++)
      check("b_cadence", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
